// File: rtl/uart_cmd_if.sv
// uart_cmd_if: groups the byte-stream input and the FIFO / trigger outputs of
// uart_cmd_decode. "master" is the side feeding bytes and observing results;
// "slave" is the decoder itself.
interface uart_cmd_if #(
    parameter int WORD_BYTES = 1
);
    logic [7:0]              rx_data;
    logic                    rx_flag;
    logic                    wr_trig;
    logic                    rd_trig;
    logic                    wfifo_wr_en;
    logic [8*WORD_BYTES-1:0] wfifo_wr_data;
    logic                    busy;
    logic                    err_timeout;
    logic                    err_chksum;

    modport master (
        output rx_data, rx_flag,
        input  wr_trig, rd_trig, wfifo_wr_en, wfifo_wr_data, busy,
               err_timeout, err_chksum
    );

    modport slave (
        input  rx_data, rx_flag,
        output wr_trig, rd_trig, wfifo_wr_en, wfifo_wr_data, busy,
               err_timeout, err_chksum
    );
endinterface

// File: rtl/uart_cmd_decode.sv
// uart_cmd_decode: parses a UART byte stream into write frames (header + payload
// bytes packed MSB-first into FIFO words) and single-byte read commands, with an
// inter-byte timeout that aborts stalled frames.
// Optional trailing XOR checksum byte: define UART_CMD_CHKSUM_EN.
module uart_cmd_decode #(
    parameter logic [7:0] WR_CMD        = 8'h55,
    parameter logic [7:0] RD_CMD        = 8'hAA,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         WORD_BYTES    = 1,
    parameter int         TIMEOUT_CYC   = 50000
) (
    input logic       clk,
    input logic       rst,
    uart_cmd_if.slave bus
);
    localparam int WW   = 8 * WORD_BYTES;
    localparam int BC_W = $clog2(PAYLOAD_BYTES) + 1;
    localparam int WC_W = $clog2(WORD_BYTES) + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [BC_W-1:0] PB_LAST = BC_W'(PAYLOAD_BYTES - 1);
    localparam logic [WC_W-1:0] WB_LAST = WC_W'(WORD_BYTES - 1);
    // The counter fires one short of TIMEOUT_CYC-1 so that the abort pulse
    // appears exactly TIMEOUT_CYC clocks after the last accepted byte.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

`ifdef UART_CMD_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHKSUM} state_t;
`else
    typedef enum logic {IDLE, PAYLOAD} state_t;
`endif

    state_t          state, state_nx;
    logic [BC_W-1:0] byte_cnt, byte_cnt_nx;
    logic [WC_W-1:0] word_cnt, word_cnt_nx;
    logic [TO_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic [WW-1:0]   shreg, shreg_nx, sh_in;
    logic            wr_en, wr_en_nx;
    logic [WW-1:0]   wr_data, wr_data_nx;
    logic            wr_trig, wr_trig_nx;
    logic            rd_trig, rd_trig_nx;
    logic            err_to, err_to_nx;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]      chk_acc, chk_acc_nx;
    logic            err_chk, err_chk_nx;
`else
    // Marks the cycle of the last FIFO strobe; wr_trig follows one cycle later.
    logic            done, done_nx;
`endif

    assign sh_in = (shreg << 8) | WW'(bus.rx_data);

    // State and all registered outputs; async reset clears everything incl. data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            tmo_cnt  <= '0;
            shreg    <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            wr_trig  <= 1'b0;
            rd_trig  <= 1'b0;
            err_to   <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            chk_acc  <= '0;
            err_chk  <= 1'b0;
`else
            done     <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
            word_cnt <= word_cnt_nx;
            tmo_cnt  <= tmo_cnt_nx;
            shreg    <= shreg_nx;
            wr_en    <= wr_en_nx;
            wr_data  <= wr_data_nx;
            wr_trig  <= wr_trig_nx;
            rd_trig  <= rd_trig_nx;
            err_to   <= err_to_nx;
`ifdef UART_CMD_CHKSUM_EN
            chk_acc  <= chk_acc_nx;
            err_chk  <= err_chk_nx;
`else
            done     <= done_nx;
`endif
        end
    end

    // Next-state, counters, shift register and one-cycle pulse generation.
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        word_cnt_nx = word_cnt;
        tmo_cnt_nx  = tmo_cnt;
        shreg_nx    = shreg;
        wr_en_nx    = 1'b0;
        wr_data_nx  = wr_data;
        wr_trig_nx  = 1'b0;
        rd_trig_nx  = 1'b0;
        err_to_nx   = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        chk_acc_nx  = chk_acc;
        err_chk_nx  = 1'b0;
`else
        done_nx     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.rx_flag) begin
                    if (bus.rx_data == WR_CMD) begin
                        state_nx    = PAYLOAD;
                        byte_cnt_nx = '0;
                        word_cnt_nx = '0;
                        tmo_cnt_nx  = '0;
                        shreg_nx    = '0;
`ifdef UART_CMD_CHKSUM_EN
                        chk_acc_nx  = '0;
`endif
                    end else if (bus.rx_data == RD_CMD) begin
                        rd_trig_nx = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
`ifndef UART_CMD_CHKSUM_EN
                if (done) begin
                    // Frame finished: trigger and release busy together.
                    wr_trig_nx = 1'b1;
                    state_nx   = IDLE;
                end else
`endif
                if (bus.rx_flag) begin
                    tmo_cnt_nx  = '0;
                    shreg_nx    = sh_in;
                    byte_cnt_nx = byte_cnt + 1'b1;
`ifdef UART_CMD_CHKSUM_EN
                    chk_acc_nx  = chk_acc ^ bus.rx_data;
`endif
                    if (word_cnt == WB_LAST) begin
                        word_cnt_nx = '0;
                        wr_en_nx    = 1'b1;
                        wr_data_nx  = sh_in;
                    end else begin
                        word_cnt_nx = word_cnt + 1'b1;
                    end
                    if (byte_cnt == PB_LAST) begin
`ifdef UART_CMD_CHKSUM_EN
                        state_nx = CHKSUM;
`else
                        done_nx  = 1'b1;
`endif
                    end
                end else if (tmo_cnt == TO_LAST) begin
                    err_to_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            CHKSUM: begin
                if (bus.rx_flag) begin
                    state_nx = IDLE;
                    if (bus.rx_data == chk_acc) wr_trig_nx = 1'b1;
                    else                        err_chk_nx = 1'b1;
                end else if (tmo_cnt == TO_LAST) begin
                    err_to_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    assign bus.wr_trig       = wr_trig;
    assign bus.rd_trig       = rd_trig;
    assign bus.wfifo_wr_en   = wr_en;
    assign bus.wfifo_wr_data = wr_data;
    assign bus.busy          = (state != IDLE);
    assign bus.err_timeout   = err_to;
`ifdef UART_CMD_CHKSUM_EN
    assign bus.err_chksum    = err_chk;
`else
    assign bus.err_chksum    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_decode.sv
// tb_uart_cmd_decode: directed and randomized byte streams against a frame-level
// reference model; expected pulses are queued with their cycle stamps and a
// monitor pops and compares them as the decoder produces outputs.
`timescale 1ns/1ps
module tb_uart_cmd_decode;
    localparam int         WB  = 2;
    localparam int         PB  = 4;
    localparam int         TO  = 20;
    localparam logic [7:0] WRC = 8'h55;
    localparam logic [7:0] RDC = 8'hAA;
    localparam int         WW  = 8 * WB;

    localparam int K_WR = 0, K_TRIG = 1, K_RD = 2, K_TO = 3, K_CHK = 4;

    typedef struct {
        int            kind;
        logic [WW-1:0] data;
        int            cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   mon_en = 1'b0;

    ev_t           exp_q[$];
    bit            busy_exp[int];
    logic [WW-1:0] held_exp;

    // frame-level reference model state
    bit         in_frame;
    bit         want_chk;
    logic [7:0] pay[$];
    int         last_cyc;
    int         blocked;

    uart_cmd_if #(.WORD_BYTES(WB)) bus();

    uart_cmd_decode #(
        .WR_CMD(WRC), .RD_CMD(RDC), .PAYLOAD_BYTES(PB),
        .WORD_BYTES(WB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_WR:    return "wfifo_wr_en";
            K_TRIG:  return "wr_trig";
            K_RD:    return "rd_trig";
            K_TO:    return "err_timeout";
            default: return "err_chksum";
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void push(int k, logic [WW-1:0] d, int c);
        ev_t e;
        e.kind = k; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        in_frame = 1'b0;
        want_chk = 1'b0;
        pay.delete();
        last_cyc = 0;
        blocked  = -1;
        busy_exp.delete();
        held_exp = '0;
    endfunction

    // Reference: what the decoder must do with input (flag, d) seen in cycle c.
    function automatic void model_step(bit flag, logic [7:0] d, int c);
        logic [WW-1:0] word;
        logic [7:0]    x;
        if (c == blocked) begin
            // decoder is wrapping up a completed frame; input ignored
        end else if (!in_frame) begin
            if (flag && d == WRC) begin
                in_frame = 1'b1;
                want_chk = 1'b0;
                pay.delete();
                last_cyc = c;
            end else if (flag && d == RDC) begin
                push(K_RD, '0, c + 1);
            end
        end else if (flag) begin
            last_cyc = c;
            if (want_chk) begin
                x = 8'h00;
                foreach (pay[i]) x ^= pay[i];
                push((d == x) ? K_TRIG : K_CHK, '0, c + 1);
                in_frame = 1'b0;
            end else begin
                pay.push_back(d);
                if (pay.size() % WB == 0) begin
                    word = '0;
                    for (int i = pay.size() - WB; i < pay.size(); i++)
                        word = (word << 8) | WW'(pay[i]);
                    push(K_WR, word, c + 1);
                end
                if (pay.size() == PB) begin
`ifdef UART_CMD_CHKSUM_EN
                    want_chk = 1'b1;
`else
                    push(K_TRIG, '0, c + 2);
                    in_frame = 1'b0;
                    blocked  = c + 1;
`endif
                end
            end
        end else if (c - last_cyc == TO - 1) begin
            push(K_TO, '0, c + 1);
            in_frame = 1'b0;
        end
        busy_exp[c + 1] = in_frame || (blocked == c + 1);
    endfunction

    task automatic drive(bit f, logic [7:0] d);
        @(negedge clk);
        bus.rx_flag = f;
        bus.rx_data = f ? d : 8'($urandom);
        model_step(f, d, cyc);
    endtask

    task automatic send(logic [7:0] d, int gap);
        repeat (gap) drive(1'b0, 8'h00);
        drive(1'b1, d);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_wr_trig"},     32'(bus.wr_trig), 0);
        chk({tag, "_rd_trig"},     32'(bus.rd_trig), 0);
        chk({tag, "_wr_en"},       32'(bus.wfifo_wr_en), 0);
        chk({tag, "_wr_data"},     32'(bus.wfifo_wr_data), 0);
        chk({tag, "_busy"},        32'(bus.busy), 0);
        chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 0);
        chk({tag, "_err_chksum"},  32'(bus.err_chksum), 0);
    endtask

    task automatic take(int k);
        ev_t e;
        compared++;
        if (exp_q.size() == 0 || exp_q[0].kind != k || exp_q[0].cyc != cyc) begin
            mismatched++;
            $display("FAIL unexpected %s @cycle %0d: got 1, expected 0", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (k == K_WR) begin
                held_exp = e.data;
                chk("wfifo_wr_data", 32'(bus.wfifo_wr_data), 32'(e.data));
            end
        end
    endtask

    // Monitor: flags missed pulses, matches presented pulses, checks busy/data hold.
    always @(negedge clk) begin
        int np;
        if (mon_en && !rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missing %s: got none at cycle %0d, required at cycle %0d",
                         kname(exp_q[0].kind), cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.wfifo_wr_en) take(K_WR);
            if (bus.wr_trig)     take(K_TRIG);
            if (bus.rd_trig)     take(K_RD);
            if (bus.err_timeout) take(K_TO);
            if (bus.err_chksum)  take(K_CHK);
            if (!bus.wfifo_wr_en) chk("wr_data_hold", 32'(bus.wfifo_wr_data), 32'(held_exp));
            if (busy_exp.exists(cyc)) chk("busy", 32'(bus.busy), 32'(busy_exp[cyc]));
            np = int'(bus.wr_trig) + int'(bus.rd_trig) + int'(bus.err_timeout) + int'(bus.err_chksum);
            if (np > 0) chk("pulse_exclusive", 32'(np), 1);
        end
    end

    task automatic rand_frame();
        logic [7:0] x;
        logic [7:0] b;
        int         g;
        x = 8'h00;
        send(WRC, $urandom_range(0, 3));
        for (int i = 0; i < PB; i++) begin
            g = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 22) : $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? WRC : RDC;
            else                           b = 8'($urandom);
            x ^= b;
            send(b, g);
        end
`ifdef UART_CMD_CHKSUM_EN
        send(($urandom_range(0, 2) == 0) ? 8'($urandom) : x, $urandom_range(0, 3));
`endif
    endtask

    initial begin
        int r;
        rst = 1'b1;
        bus.rx_flag = 1'b0;
        bus.rx_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // nominal frame, bytes 10 clocks apart
        send(WRC, 1); send(8'h12, 9); send(8'h34, 9); send(8'h56, 9); send(8'h78, 9);
`ifdef UART_CMD_CHKSUM_EN
        send(8'h08, 2);
`endif
        idle(5);
        // read command followed by a byte to ignore
        send(RDC, 0); send(8'h3C, 2); idle(4);
        // partial frame then silence: one word, then timeout, then a read
        send(WRC, 0); send(8'h12, 3); send(8'h34, 3); send(8'h56, 3);
        idle(25);
        send(RDC, 0); idle(4);
        // back-to-back bytes; header values inside the payload are data
        send(WRC, 0); send(RDC, 0); send(WRC, 0); send(8'h01, 0); send(8'h02, 0);
`ifdef UART_CMD_CHKSUM_EN
        send(8'hFC, 0);
`endif
        send(RDC, 0); idle(4);
        // timeout boundary: a byte on the last allowed cycle is accepted,
        // one cycle later the frame is aborted
        send(WRC, 0); send(8'hA1, TO - 2); send(8'hB2, TO - 1); idle(4);
`ifdef UART_CMD_CHKSUM_EN
        // good and bad checksum frames
        send(WRC, 0); send(8'h12, 1); send(8'h34, 1); send(8'h56, 1); send(8'h78, 1);
        send(8'h08, 1); idle(3);
        send(WRC, 0); send(8'h12, 1); send(8'h34, 1); send(8'h56, 1); send(8'h78, 1);
        send(8'h00, 1); idle(3);
        // timeout while waiting for the checksum byte
        send(WRC, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        idle(TO + 3);
`endif
        // reset in the middle of a frame with a partial word held
        send(WRC, 0); send(8'h9A, 1); idle(2);
        chk("pre_reset_queue_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        bus.rx_flag = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 check_all_zero("midreset");
        @(negedge clk);
        #2 rst = 1'b0;
        send(8'h12, 1); send(RDC, 1); idle(4);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      rand_frame();
            else if (r <= 7) send(RDC, $urandom_range(0, 4));
            else             send(8'($urandom), $urandom_range(0, 4));
        end
        idle(TO + 10);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
